day_2_range_scheduler: RTL
==========================

DAY_2_RANGE_SCHEDULER -- requirements
Module: day_2_range_scheduler

Interface
REQ-001 SHALL have parameter LENGTH, default 34, number of ranges processed per run (1..64).
REQ-002 SHALL have parameter CHUNK, default 1024, max IDs per dispatched job (>=1).
REQ-003 SHALL have parameter MAX_OUT, default 4, max jobs outstanding at workers (1..255).
REQ-004 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have start  input  1  begin run; sampled in IDLE or DONE.
REQ-007 SHALL have wr_en/wr_addr/wr_lo/wr_hi  input  1/6/64/64  range-table write port.
REQ-008 SHALL have job_valid/job_ready  output/input  1/1  job handshake to checker workers.
REQ-009 SHALL have job_lo/job_hi  output  64/64  inclusive ID sub-range of current job.
REQ-010 SHALL have res_valid/res_sum  input  1/64  worker partial-sum return, always accepted.
REQ-011 SHALL have busy  output  1  high in any state other than IDLE/DONE.
REQ-012 SHALL have finished/result  output  1/64  run complete; total sum.

Function
REQ-013 SHALL implement states IDLE, FETCH, DISPATCH, DRAIN, DONE.
REQ-014 SHALL write table[wr_addr] <= {wr_lo,wr_hi} on wr_en only when busy=0; writes while busy, or with wr_addr>=LENGTH, ignored.
REQ-015 SHALL, on start in IDLE or DONE: clear accumulator, outstanding, idx, finished; go FETCH next cycle.
REQ-016 SHALL in FETCH read table[idx], set cursor=lo; if lo>hi skip entry (idx+1); go DISPATCH, or DRAIN when idx reaches LENGTH.
REQ-017 SHALL in DISPATCH drive job_valid=1 only while outstanding<MAX_OUT; job_lo=cursor, job_hi=hi if (hi-cursor)<CHUNK-1 else cursor+CHUNK-1 (no 64-bit overflow).
REQ-018 SHALL hold job_valid, job_lo, job_hi stable until job_valid&job_ready.
REQ-019 SHALL on handshake: outstanding+1; if job_hi==hi then idx+1 and go FETCH (or DRAIN if idx+1==LENGTH), else cursor=job_hi+1 and stay.
REQ-020 SHALL on res_valid in FETCH/DISPATCH/DRAIN add res_sum to accumulator (mod 2^64) and outstanding-1.
REQ-021 SHALL leave outstanding unchanged on same-cycle handshake and res_valid; sum still added.
REQ-022 SHALL ignore res_valid in IDLE/DONE and when outstanding==0 (no underflow, no add).
REQ-023 SHALL in DRAIN wait until outstanding==0 with no res_valid that cycle, then go DONE.
REQ-024 SHALL in DONE drive result=accumulator, finished=1, held until start or rst.
REQ-025 SHALL deassert job_valid in every state except DISPATCH.

Reset
REQ-026 SHALL on rst: state=IDLE, finished=0, result=0, job_valid=0, busy=0, accumulator/outstanding/idx/cursor=0.
REQ-027 SHALL on rst mid-run abandon run, discard in-flight results, retain table contents.
REQ-028 SHALL give rst priority over start, wr_en and res_valid in the same cycle.

Configuration
REQ-029 SHALL, with DAY_2_CHUNK_SPLIT_EN defined, split ranges per CHUNK as in REQ-017.
REQ-030 SHALL, without DAY_2_CHUNK_SPLIT_EN, dispatch each non-empty range as one job (job_lo=lo, job_hi=hi); CHUNK ignored.

Verification
REQ-031 SHALL test LENGTH=1, CHUNK=4, range 11..22, job_ready=1, worker returns 1 per job -> jobs 11-14,15-18,19-22; result=3, finished=1.
REQ-032 SHALL test MAX_OUT=2 with no res_valid -> exactly 2 handshakes then job_valid=0; one res_valid -> third job issues.
REQ-033 SHALL test range lo=2^64-3, hi=2^64-1, CHUNK=1024 -> single job 2^64-3..2^64-1, no wrap.
REQ-034 SHALL test entry lo=50, hi=40 between valid entries -> entry skipped, no job issued for it.
REQ-035 SHALL test rst asserted in DISPATCH with 2 outstanding, then start -> accumulator 0, earlier results ignored, table intact.
REQ-036 SHALL test handshake and res_valid same cycle with outstanding=1 -> outstanding stays 1, res_sum added.

Source files
------------

// File: rtl/day_2_range_scheduler.sv
// Range scheduler: walks a table of inclusive ID ranges, hands sub-ranges to worker
// jobs and accumulates their partial sums. DAY_2_CHUNK_SPLIT_EN enables CHUNK splitting.
module day_2_range_scheduler #(
    parameter int LENGTH  = 34,
    parameter int CHUNK   = 1024,
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [63:0] wr_lo,
    input  logic [63:0] wr_hi,
    output logic        job_valid,
    input  logic        job_ready,
    output logic [63:0] job_lo,
    output logic [63:0] job_hi,
    input  logic        res_valid,
    input  logic [63:0] res_sum,
    output logic        busy,
    output logic        finished,
    output logic [63:0] result
);

`ifdef DAY_2_CHUNK_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [63:0] CHUNK_M1 = 64'(CHUNK - 1);
    localparam logic [6:0]  LEN      = 7'(LENGTH);
    localparam logic [7:0]  OUT_MAX  = 8'(MAX_OUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DISPATCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [7:0]  out_q, out_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] cursor_q, cursor_d;
    logic [63:0] hi_q, hi_d;

    logic [63:0] tbl_lo [64];
    logic [63:0] tbl_hi [64];

    logic        tbl_we;
    logic [63:0] ent_lo, ent_hi;
    logic [63:0] span;
    logic        hs, rv, last_entry;

    // Datapath and handshake decode.
    always_comb begin
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        tbl_we     = wr_en && !busy && ({1'b0, wr_addr} < LEN);
        ent_lo     = tbl_lo[idx_q[5:0]];
        ent_hi     = tbl_hi[idx_q[5:0]];
        span       = hi_q - cursor_q;
        job_lo     = cursor_q;
        // The cursor+CHUNK-1 form is only taken when it cannot pass hi, so it never wraps.
        job_hi     = (SPLIT_EN && (span >= CHUNK_M1)) ? cursor_q + CHUNK_M1 : hi_q;
        job_valid  = (state_q == S_DISPATCH) && (out_q < OUT_MAX);
        hs         = job_valid && job_ready;
        rv         = res_valid && busy && (out_q != 8'd0);
        last_entry = (idx_q + 7'd1) == LEN;
        finished   = (state_q == S_DONE);
        result     = finished ? acc_q : 64'd0;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cursor_d = cursor_q;
        hi_d     = hi_q;
        acc_d    = rv ? acc_q + res_sum : acc_q;
        case ({hs, rv})
            2'b10:   out_d = out_q + 8'd1;
            2'b01:   out_d = out_q - 8'd1;
            default: out_d = out_q;
        endcase

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    acc_d   = '0;
                    out_d   = '0;
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                if (idx_q >= LEN) begin
                    state_d = S_DRAIN;
                end else if (ent_lo > ent_hi) begin
                    idx_d   = idx_q + 7'd1;
                    state_d = last_entry ? S_DRAIN : S_FETCH;
                end else begin
                    cursor_d = ent_lo;
                    hi_d     = ent_hi;
                    state_d  = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (hs) begin
                    if (job_hi == hi_q) begin
                        idx_d   = idx_q + 7'd1;
                        state_d = last_entry ? S_DRAIN : S_FETCH;
                    end else begin
                        cursor_d = job_hi + 64'd1;
                    end
                end
            end
            S_DRAIN: begin
                if ((out_q == 8'd0) && !res_valid) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            out_q    <= '0;
            acc_q    <= '0;
            cursor_q <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            out_q    <= out_d;
            acc_q    <= acc_d;
            cursor_q <= cursor_d;
            hi_q     <= hi_d;
        end
    end

    // NOTE: the range table is not reset; its contents must survive rst and are always written before use.
    always_ff @(posedge clk) begin
        if (!rst && tbl_we) begin
            tbl_lo[wr_addr] <= wr_lo;
            tbl_hi[wr_addr] <= wr_hi;
        end
    end

endmodule
